// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// The addi states only exist when MULTICYCLE_ADDI_EN is defined.
package control_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7
`ifdef MULTICYCLE_ADDI_EN
    ,
    ADDIEXEC = 4'd8,
    ADDIWB   = 4'd9
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational Funct-to-ALUControl mapping; also flags whether Funct is
// one of the supported R-type operations.
module alu_decoder
  import control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (funct)
      FUNCT_ADD: alu_control = ALU_ADD;
      FUNCT_SUB: alu_control = ALU_SUB;
      FUNCT_AND: alu_control = ALU_AND;
      FUNCT_OR:  alu_control = ALU_OR;
      FUNCT_SLT: alu_control = ALU_SLT;
      default:   legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type, and
// addi when MULTICYCLE_ADDI_EN is defined).
module multicycle_control
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [3:0] state_o,
  output logic       instr_done_o,
  output logic       illegal_o
);

  state_t     state_reg;
  state_t     state_next;
  logic [2:0] funct_alu;
  logic       funct_legal;

  logic pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;
  logic done_raw, illegal_raw;

  alu_decoder u_alu_decoder (
    .funct       (Funct),
    .alu_control (funct_alu),
    .legal       (funct_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = FETCH;
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    done_raw      = 1'b0;
    illegal_raw   = 1'b0;
    PCSrc         = 1'b0;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUControl    = ALU_ADD;
    case (state_reg)
      FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcB      = 2'b01;
        state_next   = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_RTYPE: begin
            if (funct_legal) state_next  = EXECUTE;
            else             illegal_raw = 1'b1;
          end
          OP_LW, OP_SW: state_next = MEMADR;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_next = ADDIEXEC;
`endif
          default:      illegal_raw = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (Op == OP_LW)      state_next = MEMREAD;
        else if (Op == OP_SW) state_next = MEMWRITE;
      end
      MEMREAD: begin
        IorD       = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      MEMWRITE: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
`endif
      default: state_next = FETCH;
    endcase
  end

  // The state register already reads FETCH during reset; only the strobes
  // need masking so nothing is written while reset is held.
  assign PCWrite      = pc_write_raw  & ~reset;
  assign IRWrite      = ir_write_raw  & ~reset;
  assign RegWrite     = reg_write_raw & ~reset;
  assign MemWrite     = mem_write_raw & ~reset;
  assign instr_done_o = done_raw      & ~reset;
  assign illegal_o    = illegal_raw   & ~reset;
  assign state_o      = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: per-cycle expected state and
// control words are queued per instruction and popped as the DUT steps.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       PCWrite, PCSrc, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] state_o;
  logic       instr_done_o, illegal_o;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .state_o(state_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCSrc,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,done,illegal}
  logic [15:0] ctrl_act;
  assign ctrl_act = {PCWrite, PCSrc, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                     ALUSrcA, ALUSrcB, ALUControl, instr_done_o, illegal_o};
  localparam logic [15:0] STROBE_MASK = 16'b1001_1001_0000_0011;

  typedef struct packed {
    logic [5:0]      op;
    logic [5:0]      funct;
    logic [2:0]      n;
    logic [4:0][3:0] st;
    logic [2:0]      alu;
    logic            ill;
  } vec_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic [15:0] ctrl_for(logic [3:0] st, logic [2:0] alu, logic ill);
    logic pcw, pcs, iord, mw, irw, rd, m2r, rw, sa, done, il;
    logic [1:0] sb;
    logic [2:0] ac;
    {pcw, pcs, iord, mw, irw, rd, m2r, rw, sa, done, il} = '0;
    sb = 2'b00;
    ac = 3'b010;
    case (st)
      4'd0: begin pcw = 1; irw = 1; sb = 2'b01; end
      4'd1: begin sb = 2'b11; il = ill; end
      4'd2: begin sa = 1; sb = 2'b10; end
      4'd3: iord = 1;
      4'd4: begin m2r = 1; rw = 1; done = 1; end
      4'd5: begin iord = 1; mw = 1; done = 1; end
      4'd6: begin sa = 1; ac = alu; end
      4'd7: begin rd = 1; rw = 1; done = 1; end
      4'd8: begin sa = 1; sb = 2'b10; end
      4'd9: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcs, iord, mw, irw, rd, m2r, rw, sa, sb, ac, done, il};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add_vec(logic [5:0] op, logic [5:0] funct, logic [2:0] n,
                                  logic [3:0] s0, logic [3:0] s1, logic [3:0] s2,
                                  logic [3:0] s3, logic [3:0] s4,
                                  logic [2:0] alu, logic ill);
    vec_t v;
    v.op = op; v.funct = funct; v.n = n;
    v.st = {s4, s3, s2, s1, s0};
    v.alu = alu; v.ill = ill;
    vecs.push_back(v);
  endfunction

  // Called at a falling edge while the DUT sits in FETCH.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int done_cnt = 0;
    Op = v.op;
    Funct = v.funct;
    for (int k = 0; k < int'(v.n); k++) begin
      e.st   = v.st[k];
      e.ctrl = ctrl_for(v.st[k], v.alu, v.ill);
      exp_q.push_back(e);
    end
    for (int k = 0; k < int'(v.n); k++) begin
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d_state_c%0d", idx, k), 32'(state_o), 32'(e.st));
      check($sformatf("v%0d_ctrl_c%0d", idx, k), 32'(ctrl_act), 32'(e.ctrl));
      if (RegWrite && MemWrite) check("rw_mw_excl", 32'(1), 32'(0));
      if (instr_done_o) done_cnt++;
      @(negedge clk);
    end
    #1;
    check($sformatf("v%0d_ret_fetch", idx), 32'(state_o), 32'(0));
    check($sformatf("v%0d_done_cnt", idx), 32'(done_cnt), v.ill ? 32'(0) : 32'(1));
    $display("instr %0d op=%b funct=%b cycles=%0d illegal=%0d", idx, v.op, v.funct, v.n, v.ill);
  endtask

  initial begin
    add_vec(6'b100011, 6'b000000, 3'd5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 3'b010, 1'b0); // lw
    add_vec(6'b101011, 6'b000000, 3'd4, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 3'b010, 1'b0); // sw
    add_vec(6'b000000, 6'b100010, 3'd4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 3'b110, 1'b0); // sub
    add_vec(6'b000000, 6'b101010, 3'd4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 3'b111, 1'b0); // slt
    add_vec(6'b000000, 6'b100000, 3'd4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 3'b010, 1'b0); // add
    add_vec(6'b000000, 6'b100100, 3'd4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 3'b000, 1'b0); // and
    add_vec(6'b000000, 6'b100101, 3'd4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 3'b001, 1'b0); // or
    add_vec(6'b000010, 6'b100000, 3'd2, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 3'b010, 1'b1); // j: illegal
    add_vec(6'b000000, 6'b000000, 3'd2, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 3'b010, 1'b1); // bad funct
`ifdef MULTICYCLE_ADDI_EN
    add_vec(6'b001000, 6'b000000, 3'd4, 4'd0, 4'd1, 4'd8, 4'd9, 4'd0, 3'b010, 1'b0); // addi
`else
    add_vec(6'b001000, 6'b000000, 3'd2, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 3'b010, 1'b1); // addi off
`endif
    add_vec(6'b100011, 6'b100010, 3'd5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 3'b010, 1'b0); // lw again

    // Reset state: FETCH with strobes masked.
    reset = 1'b1;
    Op = 6'b0;
    Funct = 6'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state_o), 32'(0));
    check("rst_ctrl", 32'(ctrl_act), 32'(ctrl_for(4'd0, 3'b010, 1'b0) & ~STROBE_MASK));
    reset = 1'b0;
    #1;
    check("rel_pcwrite", 32'(PCWrite), 32'(1));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset pulse in MEMREAD: abandon lw without a write strobe.
    Op = 6'b100011;
    Funct = 6'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mid_memread", 32'(state_o), 32'(3));
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(state_o), 32'(0));
    check("mid_rst_ctrl", 32'(ctrl_act), 32'(ctrl_for(4'd0, 3'b010, 1'b0) & ~STROBE_MASK));
    @(posedge clk);
    #1;
    check("mid_rst_hold_state", 32'(state_o), 32'(0));
    check("mid_rst_hold_strobe", 32'(ctrl_act & STROBE_MASK), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rel_pcwrite", 32'(PCWrite), 32'(1));
    check("mid_rel_irwrite", 32'(IRWrite), 32'(1));
    @(negedge clk);
    #1;
    check("mid_rel_decode", 32'(state_o), 32'(1));
    repeat (4) @(negedge clk);
    #1;
    check("mid_rel_lw_done", 32'(state_o), 32'(0));
    $display("instr reset-during-memread sequence complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
